// File: rtl/rob_complete.sv
// Reorder buffer with three-port completion and dual in-order retire.
// Retire outputs are registered; head/tail wrap modulo DEPTH.
module rob_complete #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alloc_valid,
  input  logic [AREG_W-1:0]     i_alloc_areg,
  input  logic [PREG_W-1:0]     i_alloc_preg,
  input  logic [PREG_W-1:0]     i_alloc_old_preg,
  input  logic                  i_alloc_regwrite,
  input  logic                  i_alloc_memwrite,
  output logic                  o_alloc_ready,
  output logic [IDX_W-1:0]      o_alloc_rob_num,
  input  logic [2:0]            i_cmp_valid,
  input  logic [3*IDX_W-1:0]    i_cmp_rob_num,
  input  logic [3*DATA_W-1:0]   i_cmp_result,
  output logic [1:0]            o_ret_valid,
  output logic [2*AREG_W-1:0]   o_ret_areg,
  output logic [2*PREG_W-1:0]   o_ret_preg,
  output logic [2*PREG_W-1:0]   o_ret_old_preg,
  output logic [1:0]            o_ret_regwrite,
  output logic [1:0]            o_ret_memwrite,
  output logic [2*DATA_W-1:0]   o_ret_data,
  output logic [IDX_W:0]        o_count
);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old_preg;
    logic              regwrite;
    logic              memwrite;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t rob_q [DEPTH];
  entry_t rob_d [DEPTH];

  idx_t head_q, head_d;
  idx_t tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [1:0]          ret_valid_q, ret_valid_d;
  logic [2*AREG_W-1:0] ret_areg_q, ret_areg_d;
  logic [2*PREG_W-1:0] ret_preg_q, ret_preg_d;
  logic [2*PREG_W-1:0] ret_old_q, ret_old_d;
  logic [1:0]          ret_rw_q, ret_rw_d;
  logic [1:0]          ret_mw_q, ret_mw_d;
  logic [2*DATA_W-1:0] ret_data_q, ret_data_d;

  logic alloc_ready;
  logic alloc_fire;
  logic ret0;
  logic ret1;
  idx_t head1;
  idx_t cidx;

  assign alloc_ready = (count_q != cnt_t'(DEPTH));
  assign alloc_fire  = i_alloc_valid && alloc_ready;
  assign head1       = head_q + idx_t'(1);
  assign ret0        = rob_q[head_q].valid && rob_q[head_q].done;
  assign ret1        = ret0 && rob_q[head1].valid && rob_q[head1].done;

  always_comb begin
    rob_d       = rob_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    ret_valid_d = '0;
    ret_areg_d  = '0;
    ret_preg_d  = '0;
    ret_old_d   = '0;
    ret_rw_d    = '0;
    ret_mw_d    = '0;
    ret_data_d  = '0;
    cidx        = '0;

    // Descending order lets the lowest FU win a shared target.
    for (int k = 2; k >= 0; k--) begin
      cidx = i_cmp_rob_num[k*IDX_W +: IDX_W];
      if (i_cmp_valid[k] && rob_q[cidx].valid &&
          !rob_q[cidx].done) begin
        rob_d[cidx].done = 1'b1;
        rob_d[cidx].data = i_cmp_result[k*DATA_W +: DATA_W];
      end
    end

    if (ret0) begin
      ret_valid_d[0]           = 1'b1;
      ret_areg_d[AREG_W-1:0]   = rob_q[head_q].areg;
      ret_preg_d[PREG_W-1:0]   = rob_q[head_q].preg;
      ret_old_d[PREG_W-1:0]    = rob_q[head_q].old_preg;
      ret_rw_d[0]              = rob_q[head_q].regwrite;
      ret_mw_d[0]              = rob_q[head_q].memwrite;
      ret_data_d[DATA_W-1:0]   = rob_q[head_q].data;
      rob_d[head_q].valid      = 1'b0;
      rob_d[head_q].done       = 1'b0;
    end

    if (ret1) begin
      ret_valid_d[1]                  = 1'b1;
      ret_areg_d[2*AREG_W-1:AREG_W]   = rob_q[head1].areg;
      ret_preg_d[2*PREG_W-1:PREG_W]   = rob_q[head1].preg;
      ret_old_d[2*PREG_W-1:PREG_W]    = rob_q[head1].old_preg;
      ret_rw_d[1]                     = rob_q[head1].regwrite;
      ret_mw_d[1]                     = rob_q[head1].memwrite;
      ret_data_d[2*DATA_W-1:DATA_W]   = rob_q[head1].data;
      rob_d[head1].valid              = 1'b0;
      rob_d[head1].done               = 1'b0;
    end

    // Tail never aliases a retiring head: that requires full, which blocks alloc.
    if (alloc_fire) begin
      rob_d[tail_q].valid    = 1'b1;
      rob_d[tail_q].done     = 1'b0;
      rob_d[tail_q].areg     = i_alloc_areg;
      rob_d[tail_q].preg     = i_alloc_preg;
      rob_d[tail_q].old_preg = i_alloc_old_preg;
      rob_d[tail_q].regwrite = i_alloc_regwrite;
      rob_d[tail_q].memwrite = i_alloc_memwrite;
      rob_d[tail_q].data     = '0;
    end

    head_d  = head_q + idx_t'(ret0) + idx_t'(ret1);
    tail_d  = tail_q + idx_t'(alloc_fire);
    count_d = count_q + cnt_t'(alloc_fire)
            - cnt_t'(ret0) - cnt_t'(ret1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_q <= '0;
      ret_areg_q  <= '0;
      ret_preg_q  <= '0;
      ret_old_q   <= '0;
      ret_rw_q    <= '0;
      ret_mw_q    <= '0;
      ret_data_q  <= '0;
    end else begin
      rob_q       <= rob_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ret_valid_q <= ret_valid_d;
      ret_areg_q  <= ret_areg_d;
      ret_preg_q  <= ret_preg_d;
      ret_old_q   <= ret_old_d;
      ret_rw_q    <= ret_rw_d;
      ret_mw_q    <= ret_mw_d;
      ret_data_q  <= ret_data_d;
    end
  end

  assign o_alloc_ready   = alloc_ready;
  assign o_alloc_rob_num = tail_q;
  assign o_count         = count_q;
  assign o_ret_valid     = ret_valid_q;
  assign o_ret_areg      = ret_areg_q;
  assign o_ret_preg      = ret_preg_q;
  assign o_ret_old_preg  = ret_old_q;
  assign o_ret_regwrite  = ret_rw_q;
  assign o_ret_memwrite  = ret_mw_q;
  assign o_ret_data      = ret_data_q;

endmodule

// File: tb/tb_rob_complete.sv
// Directed self-checking bench for rob_complete.
// Inputs change #1 after posedge; outputs checked at the same point.
module tb_rob_complete;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_alloc_valid = 1'b0;
  logic [4:0]  i_alloc_areg = '0;
  logic [5:0]  i_alloc_preg = '0;
  logic [5:0]  i_alloc_old_preg = '0;
  logic        i_alloc_regwrite = 1'b0;
  logic        i_alloc_memwrite = 1'b0;
  logic        o_alloc_ready;
  logic [3:0]  o_alloc_rob_num;
  logic [2:0]  i_cmp_valid = '0;
  logic [11:0] i_cmp_rob_num = '0;
  logic [95:0] i_cmp_result = '0;
  logic [1:0]  o_ret_valid;
  logic [9:0]  o_ret_areg;
  logic [11:0] o_ret_preg;
  logic [11:0] o_ret_old_preg;
  logic [1:0]  o_ret_regwrite;
  logic [1:0]  o_ret_memwrite;
  logic [63:0] o_ret_data;
  logic [4:0]  o_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rob_complete dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_alloc_valid(i_alloc_valid),
    .i_alloc_areg(i_alloc_areg),
    .i_alloc_preg(i_alloc_preg),
    .i_alloc_old_preg(i_alloc_old_preg),
    .i_alloc_regwrite(i_alloc_regwrite),
    .i_alloc_memwrite(i_alloc_memwrite),
    .o_alloc_ready(o_alloc_ready),
    .o_alloc_rob_num(o_alloc_rob_num),
    .i_cmp_valid(i_cmp_valid),
    .i_cmp_rob_num(i_cmp_rob_num),
    .i_cmp_result(i_cmp_result),
    .o_ret_valid(o_ret_valid),
    .o_ret_areg(o_ret_areg),
    .o_ret_preg(o_ret_preg),
    .o_ret_old_preg(o_ret_old_preg),
    .o_ret_regwrite(o_ret_regwrite),
    .o_ret_memwrite(o_ret_memwrite),
    .o_ret_data(o_ret_data),
    .o_count(o_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_alloc_valid = 1'b0;
    i_cmp_valid = '0;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic alloc(input logic [5:0] p);
    i_alloc_valid    = 1'b1;
    i_alloc_areg     = p[4:0];
    i_alloc_preg     = p;
    i_alloc_old_preg = p ^ 6'h3f;
    i_alloc_regwrite = 1'b1;
    i_alloc_memwrite = p[0];
    tick();
    i_alloc_valid    = 1'b0;
  endtask

  task automatic cmp(input logic [2:0] v,
                     input logic [3:0] r0, input logic [3:0] r1,
                     input logic [3:0] r2,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [31:0] d2);
    i_cmp_valid   = v;
    i_cmp_rob_num = {r2, r1, r0};
    i_cmp_result  = {d2, d1, d0};
    tick();
    i_cmp_valid   = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_count !== 5'd0) begin
      errors++; $display("FAIL rst_count got %0d want 0", o_count);
    end
    checks++;
    if (o_alloc_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready got %b want 1", o_alloc_ready);
    end
    checks++;
    if (o_alloc_rob_num !== 4'd0) begin
      errors++; $display("FAIL rst_robnum got %0d want 0", o_alloc_rob_num);
    end
    checks++;
    if (o_ret_valid !== 2'b00 || o_ret_data !== 64'd0 ||
        o_ret_preg !== 12'd0) begin
      errors++; $display("FAIL rst_ret got v=%b d=%h want 0", o_ret_valid, o_ret_data);
    end
  endtask

  task automatic test_ooo_complete();
    do_reset();
    alloc(6'd10); alloc(6'd11); alloc(6'd12);
    checks++;
    if (o_count !== 5'd3 || o_alloc_rob_num !== 4'd3) begin
      errors++; $display("FAIL ooo_alloc got cnt=%0d num=%0d want 3 3", o_count, o_alloc_rob_num);
    end
    cmp(3'b001, 4'd1, 4'd0, 4'd0, 32'h101, 0, 0);
    checks++;
    if (o_ret_valid !== 2'b00) begin
      errors++; $display("FAIL ooo_wait1 got %b want 00", o_ret_valid);
    end
    cmp(3'b001, 4'd0, 4'd0, 4'd0, 32'h100, 0, 0);
    checks++;
    if (o_ret_valid !== 2'b00 || o_count !== 5'd3) begin
      errors++; $display("FAIL ooo_wait2 got v=%b cnt=%0d want 00 3", o_ret_valid, o_count);
    end
    tick();
    checks++;
    if (o_ret_valid !== 2'b11 || o_ret_preg !== {6'd11, 6'd10} ||
        o_ret_old_preg !== {6'd11 ^ 6'h3f, 6'd10 ^ 6'h3f} ||
        o_ret_areg !== {5'd11, 5'd10} || o_ret_memwrite !== 2'b10 ||
        o_ret_regwrite !== 2'b11) begin
      errors++; $display("FAIL ooo_ret got v=%b preg=%h want 11 %h", o_ret_valid, o_ret_preg, {6'd11, 6'd10});
    end
    checks++;
    if (o_ret_data !== {32'h101, 32'h100} || o_count !== 5'd1) begin
      errors++; $display("FAIL ooo_data got d=%h cnt=%0d want 0000010100000100 1", o_ret_data, o_count);
    end
    tick();
    checks++;
    if (o_ret_valid !== 2'b00 || o_ret_data !== 64'd0) begin
      errors++; $display("FAIL ooo_idle got v=%b d=%h want 00 0", o_ret_valid, o_ret_data);
    end
  endtask

  task automatic test_triple();
    do_reset();
    alloc(6'd20); alloc(6'd21); alloc(6'd22);
    cmp(3'b111, 4'd0, 4'd1, 4'd2, 32'hA, 32'hB, 32'hC);
    checks++;
    if (o_ret_valid !== 2'b00) begin
      errors++; $display("FAIL tri_lat got %b want 00", o_ret_valid);
    end
    tick();
    checks++;
    if (o_ret_valid !== 2'b11 || o_ret_data !== {32'hB, 32'hA} ||
        o_count !== 5'd1) begin
      errors++; $display("FAIL tri_ret01 got v=%b d=%h cnt=%0d want 11 0000000b0000000a 1", o_ret_valid, o_ret_data, o_count);
    end
    tick();
    checks++;
    if (o_ret_valid !== 2'b01 || o_ret_data !== {32'h0, 32'hC} ||
        o_ret_preg !== {6'd0, 6'd22} || o_count !== 5'd0) begin
      errors++; $display("FAIL tri_ret2 got v=%b d=%h cnt=%0d want 01 c 0", o_ret_valid, o_ret_data, o_count);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) alloc(6'(i));
    checks++;
    if (o_alloc_ready !== 1'b0 || o_count !== 5'd16 ||
        o_alloc_rob_num !== 4'd0) begin
      errors++; $display("FAIL full_state got rdy=%b cnt=%0d num=%0d want 0 16 0", o_alloc_ready, o_count, o_alloc_rob_num);
    end
    alloc(6'd63);
    checks++;
    if (o_count !== 5'd16 || o_alloc_rob_num !== 4'd0) begin
      errors++; $display("FAIL full_drop got cnt=%0d num=%0d want 16 0", o_count, o_alloc_rob_num);
    end
    cmp(3'b010, 4'd0, 4'd0, 4'd0, 0, 32'h77, 0);
    i_alloc_valid = 1'b1;
    i_alloc_preg  = 6'd62;
    tick();
    i_alloc_valid = 1'b0;
    checks++;
    if (o_count !== 5'd15 || o_alloc_ready !== 1'b1 ||
        o_alloc_rob_num !== 4'd0) begin
      errors++; $display("FAIL full_block got cnt=%0d rdy=%b num=%0d want 15 1 0", o_count, o_alloc_ready, o_alloc_rob_num);
    end
    checks++;
    if (o_ret_valid !== 2'b01 || o_ret_preg[5:0] !== 6'd0 ||
        o_ret_data[31:0] !== 32'h77) begin
      errors++; $display("FAIL full_ret got v=%b preg=%0d d=%h want 01 0 77", o_ret_valid, o_ret_preg[5:0], o_ret_data[31:0]);
    end
  endtask

  task automatic test_wrap();
    logic [5:0] p;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      p = 6'(i + 30);
      checks++;
      if (o_alloc_rob_num !== 4'(i % 16)) begin
        errors++; $display("FAIL wrap_num%0d got %0d want %0d", i, o_alloc_rob_num, i % 16);
      end
      alloc(p);
      cmp(3'b100, 4'd0, 4'd0, 4'(i % 16), 0, 0, 32'(i));
      tick();
      checks++;
      if (o_ret_valid !== 2'b01 || o_ret_preg[5:0] !== p ||
          o_ret_data[31:0] !== 32'(i)) begin
        errors++; $display("FAIL wrap_ret%0d got v=%b preg=%0d want 01 %0d", i, o_ret_valid, o_ret_preg[5:0], p);
      end
    end
  endtask

  task automatic test_dup();
    do_reset();
    for (int i = 0; i < 6; i++) alloc(6'(40 + i));
    cmp(3'b001, 4'd5, 4'd0, 4'd0, 32'h11, 0, 0);
    cmp(3'b110, 4'd0, 4'd5, 4'd9, 0, 32'h22, 32'h99);
    cmp(3'b110, 4'd0, 4'd4, 4'd4, 0, 32'h44, 32'h55);
    checks++;
    if (o_count !== 5'd6 || o_ret_valid !== 2'b00) begin
      errors++; $display("FAIL dup_hold got cnt=%0d v=%b want 6 00", o_count, o_ret_valid);
    end
    cmp(3'b111, 4'd0, 4'd1, 4'd2, 32'h1, 32'h2, 32'h3);
    cmp(3'b001, 4'd3, 4'd0, 4'd0, 32'h4, 0, 0);
    checks++;
    if (o_ret_valid !== 2'b11 || o_ret_preg !== {6'd41, 6'd40}) begin
      errors++; $display("FAIL dup_r01 got v=%b preg=%h want 11 %h", o_ret_valid, o_ret_preg, {6'd41, 6'd40});
    end
    tick();
    tick();
    checks++;
    if (o_ret_valid !== 2'b11 || o_ret_data !== {32'h11, 32'h44}) begin
      errors++; $display("FAIL dup_data got v=%b d=%h want 11 0000001100000044", o_ret_valid, o_ret_data);
    end
    tick();
    checks++;
    if (o_count !== 5'd0 || o_ret_valid !== 2'b00) begin
      errors++; $display("FAIL dup_empty got cnt=%0d v=%b want 0 00", o_count, o_ret_valid);
    end
    for (int i = 6; i < 10; i++) alloc(6'(40 + i));
    cmp(3'b111, 4'd6, 4'd7, 4'd8, 32'h6, 32'h7, 32'h8);
    tick();
    tick();
    checks++;
    if (o_ret_valid !== 2'b01 || o_ret_preg[5:0] !== 6'd48 ||
        o_count !== 5'd1) begin
      errors++; $display("FAIL dup_stale9 got v=%b preg=%0d cnt=%0d want 01 48 1", o_ret_valid, o_ret_preg[5:0], o_count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(6'(i + 1));
    cmp(3'b001, 4'd0, 4'd0, 4'd0, 32'h5, 0, 0);
    i_rst         = 1'b1;
    i_alloc_valid = 1'b1;
    i_cmp_valid   = 3'b001;
    i_cmp_rob_num = {4'd0, 4'd0, 4'd1};
    tick();
    i_rst         = 1'b0;
    i_alloc_valid = 1'b0;
    i_cmp_valid   = '0;
    checks++;
    if (o_count !== 5'd0 || o_ret_valid !== 2'b00 ||
        o_alloc_rob_num !== 4'd0 || o_alloc_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid got cnt=%0d v=%b num=%0d want 0 00 0", o_count, o_ret_valid, o_alloc_rob_num);
    end
    tick();
    checks++;
    if (o_ret_valid !== 2'b00 || o_count !== 5'd0) begin
      errors++; $display("FAIL rstmid_after got v=%b cnt=%0d want 00 0", o_ret_valid, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_ooo_complete();
    test_triple();
    test_full();
    test_wrap();
    test_dup();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_complete.md
Name: rob_complete

Overview:
- Reorder buffer and complete stage, sitting directly downstream of the issue/execute stage.
- Allocates one entry per dispatched instruction in program order.
- Accepts up to three functional-unit completion results per cycle (ALU0, ALU1, LSU), tagged by ROB number.
- Retires up to two completed entries per cycle in order; retirement drives architectural register commit, store commit and physical-register free-list release.

Parameters:
- DEPTH, 16, number of ROB entries (power of two, ≥4)
- IDX_W, 4, ROB index width, equal to log2(DEPTH)
- PREG_W, 6, physical register address width
- AREG_W, 5, architectural register address width
- DATA_W, 32, result word width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_alloc_valid  in  1  dispatch requests an entry this cycle
- i_alloc_areg  in  AREG_W  architectural destination
- i_alloc_preg  in  PREG_W  newly mapped physical destination
- i_alloc_old_preg  in  PREG_W  previous mapping, freed at retire
- i_alloc_regwrite  in  1  instruction writes a register
- i_alloc_memwrite  in  1  instruction is a store
- o_alloc_ready  out  1  entry available (not full)
- o_alloc_rob_num  out  IDX_W  index assigned to the current alloc (equals tail)
- i_cmp_valid  in  3  per-FU completion valid (bit0 ALU0, bit1 ALU1, bit2 LSU)
- i_cmp_rob_num  in  3×IDX_W  per-FU ROB number
- i_cmp_result  in  3×DATA_W  per-FU result
- o_ret_valid  out  2  retire slot valid (slot0 oldest)
- o_ret_areg  out  2×AREG_W  committed architectural register
- o_ret_preg  out  2×PREG_W  committed physical register
- o_ret_old_preg  out  2×PREG_W  physical register to free
- o_ret_regwrite  out  2  commit a register write
- o_ret_memwrite  out  2  commit a store
- o_ret_data  out  2×DATA_W  committed result
- o_count  out  IDX_W+1  occupied entries

Behaviour:
- State: entry array of {valid, done, areg, preg, old_preg, regwrite, memwrite, data}; head and tail pointers (IDX_W bits, wrap modulo DEPTH); count (IDX_W+1 bits).
- Reset, synchronous on i_rst high:
  - head = tail = count = 0; all valid/done = 0.
  - o_ret_valid = 0, other o_ret_* = 0.
  - o_alloc_ready = 1, o_alloc_rob_num = 0, o_count = 0.
  - Reset overrides any same-cycle alloc, completion or retire.
- Allocation:
  - Fires when i_alloc_valid && o_alloc_ready.
  - Writes the entry at tail with valid = 1, done = 0; tail increments.
  - o_alloc_ready = (count != DEPTH), combinational from registered count.
  - Alloc while full is dropped; no state changes.
- Completion:
  - For each FU k with i_cmp_valid[k], and entry[rob_num] valid and not done: set done = 1 and latch data.
  - Completion to an invalid or already-done entry is ignored, including duplicates.
  - Two FUs naming the same entry in one cycle: the lowest k wins.
  - Completion data is visible to retire the next cycle, so minimum complete-to-retire latency is 1 cycle.
- Retire (registered outputs):
  - Slot0 retires head if valid && done.
  - Slot1 retires head+1 only if slot0 retires and head+1 is valid && done.
  - Retired entries are cleared (valid = 0, done = 0); head advances by the number retired (0–2).
  - o_ret_* are asserted the cycle after the retire decision. Unused slots drive o_ret_valid = 0 with other fields held at 0.
- Count:
  - count_next = count + alloc_fire − num_retired.
  - Alloc and retire in the same cycle while full: the alloc is blocked, because ready is based on the current count. The freed slot is usable the next cycle.
- Wrap: head, tail and head+1 wrap from DEPTH−1 to 0 with no bubble.
- Empty: no retire; completions are ignored.

Test Plan:
- Reset, then alloc 3 entries (preg 10, 11, 12); complete ROB#1 then ROB#0 on the following cycle → nothing retires until #0 is done; the cycle after, slots 0 and 1 retire preg 10 and 11 in order; o_count goes 3→1.
- Same-cycle triple completion of ROB#0, 1, 2 with results 0xA, 0xB, 0xC → next cycle retire #0 and #1 (data 0xA, 0xB); the following cycle retire #2 (0xC).
- Fill 16 entries → o_alloc_ready = 0, and a 17th alloc is dropped (tail unchanged); complete and retire the head → o_alloc_ready = 1 the next cycle.
- Wrap: alloc and retire 20 instructions in sequence → o_alloc_rob_num sequence 0…15, 0…3; retire order preserved across the wrap.
- Duplicate/stale completion: complete ROB#5 twice (0x11, then 0x22) and complete an unallocated ROB#9 → retired data for #5 is 0x11; #9 is unaffected.
- Assert i_rst with 4 entries pending and a completion present → the next cycle shows o_count = 0, o_ret_valid = 0, o_alloc_rob_num = 0.
